// File: rtl/clk_div_multi.sv
// clk_div_multi: NUM_CH independent 50%-duty clock dividers (any divisor) sharing clk_i.
//   arst_ni : async active-low reset      clk_i  : input clock (both edges used)
//   en_i    : per-channel run enable      div_i  : packed divisors, DIV_WIDTH each
//   load_i  : per-channel divisor load    sync_i : global phase-align strobe
//   clk_o   : divided clocks              tick_o : one-cycle pulse per clk_o rise
//   pend_o  : divisor update pending
module clk_div_multi #(
    parameter int NUM_CH    = 4,
    parameter int DIV_WIDTH = 4,
    parameter int DIV_RESET = 1
) (
    input  logic                        arst_ni,
    input  logic                        clk_i,
    input  logic [NUM_CH-1:0]           en_i,
    input  logic [NUM_CH*DIV_WIDTH-1:0] div_i,
    input  logic [NUM_CH-1:0]           load_i,
    input  logic                        sync_i,
    output logic [NUM_CH-1:0]           clk_o,
    output logic [NUM_CH-1:0]           tick_o,
    output logic [NUM_CH-1:0]           pend_o
);
    localparam int W  = DIV_WIDTH;
    localparam int SW = 2 * W + 2;
    localparam logic [W-1:0]  ONE    = W'(1);
    localparam logic [SW-1:0] ST_RST = {2'b00, W'(DIV_RESET), W'(0)};

    logic [NUM_CH-1:0] en_q;
    logic              sync_q;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            en_q   <= '0;
            sync_q <= 1'b0;
        end else begin
            en_q   <= en_i;
            sync_q <= sync_i;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [W-1:0]  sh, cnt, act, act_nx, d_nx, cnt_nx;
        logic [SW-1:0] sp, sn, st, np, nn;
        logic          pend, clk, bnd, hold, clk_nx, rp, rn, tick;

        // Dual-edge state: one half lives in a rising-edge register, the other in a
        // falling-edge register; their XOR is the state, and each edge rewrites its
        // own half so that the XOR becomes the next state.
        assign st                     = sp ^ sn;
        assign {pend, clk, act, cnt}  = st;

        // Period boundary is the edge where clk would rise; a stopped channel sits here.
        assign bnd    = cnt == '0 && !clk;
        assign hold   = bnd && !en_q[c];
        assign act_nx = (bnd && pend) ? sh : act;
        assign d_nx   = (act_nx == '0) ? ONE : act_nx;
        assign cnt_nx = hold || cnt == d_nx - ONE ? '0 : cnt + ONE;
        assign clk_nx = hold ? 1'b0 : clk ^ (cnt == '0);

        // Rising edge: normal step, load strobe may set pending.
        assign np = {load_i[c] | (pend & !bnd), clk_nx, act_nx, cnt_nx};
        // Falling edge: a sync sampled on the previous rising edge forces phase zero
        // and applies any pending divisor.
        assign nn = sync_q ? {2'b00, pend ? sh : act, W'(0)}
                           : {pend & !bnd, clk_nx, act_nx, cnt_nx};

        always_ff @(posedge clk_i or negedge arst_ni) begin
            if (!arst_ni) begin
                sp   <= ST_RST;
                sh   <= W'(DIV_RESET);
                rp   <= 1'b0;
                tick <= 1'b0;
            end else begin
                sp   <= np ^ sn;
                sh   <= load_i[c] ? div_i[c*W +: W] : sh;
                rp   <= clk_nx & !clk;
                // A rise on the previous rising edge or on the falling edge between
                // can never both happen, so this yields one tick per rise.
                tick <= rp | rn;
            end
        end

        always_ff @(negedge clk_i or negedge arst_ni) begin
            if (!arst_ni) begin
                sn <= '0;
                rn <= 1'b0;
            end else begin
                sn <= nn ^ sp;
                rn <= nn[SW-2] & !clk;
            end
        end

        assign clk_o[c]  = clk;
        assign pend_o[c] = pend;
        assign tick_o[c] = tick;
    end
endmodule
